// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, default widths and the branch-target table.
// Optional feature macro used by pc_fetch: RELATIVE_BRANCH_EN (table entries become signed offsets).
package pc_fetch_pkg;

    localparam int unsigned FETCH_PC_W      = 10;
    localparam int unsigned FETCH_LUT_IDX_W = 4;
    localparam int unsigned FETCH_CNT_W     = 16;
    localparam int unsigned LUT_DEPTH       = 2 ** FETCH_LUT_IDX_W;
    localparam int unsigned LUT_ENTRY_W     = FETCH_PC_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef logic [LUT_ENTRY_W-1:0] lut_entry_t;

    // Entry 4 reads as 1020 absolute or -4 as a relative offset
    localparam lut_entry_t BRANCH_LUT [LUT_DEPTH] = '{
        10'd0,   10'd4,   10'd12,  10'd40,
        10'h3FC, 10'd0,   10'd0,   10'd0,
        10'd0,   10'd0,   10'd0,   10'd0,
        10'd0,   10'd0,   10'd0,   10'd0
    };

endpackage

// File: rtl/pc_fetch_if.sv
// Control/status bundle between the program driver and the fetch stage.
interface pc_fetch_if #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned LUT_IDX_W = 4,
    parameter int unsigned CNT_W     = 16
) ();

    logic                 start;
    logic                 jumpFlag;
    logic [LUT_IDX_W-1:0] jumpIdx;
    logic                 haltReq;
    logic [PC_W-1:0]      pc;
    logic                 running;
    logic                 done;
    logic [CNT_W-1:0]     cycleCount;

    modport master (
        output start, jumpFlag, jumpIdx, haltReq,
        input  pc, running, done, cycleCount
    );

    modport slave (
        input  start, jumpFlag, jumpIdx, haltReq,
        output pc, running, done, cycleCount
    );

endinterface

// File: rtl/pc_fetch_branch_lut.sv
// Combinational branch-table lookup: index in, raw table entry out.
module pc_fetch_branch_lut
    import pc_fetch_pkg::*;
#(
    parameter int unsigned IDX_W = FETCH_LUT_IDX_W
) (
    input  logic [IDX_W-1:0] i_idx,
    output lut_entry_t       o_entry
);

    always_comb begin
        o_entry = '0;
        for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_entry = BRANCH_LUT[i];
            end
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencing: IDLE/RUN/HALTED control, branch-table jumps, run-cycle counter.
// Build option RELATIVE_BRANCH_EN: table entries are signed offsets added to the current pc.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int unsigned PC_W       = FETCH_PC_W,
    parameter int unsigned LUT_IDX_W  = FETCH_LUT_IDX_W,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = FETCH_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    pc_fetch_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [PC_W-1:0]  PC_START = PC_W'(START_ADDR);

    fetch_state_t     r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_running;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    lut_entry_t       w_entry;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_pc_inc;

    pc_fetch_branch_lut #(
        .IDX_W (LUT_IDX_W)
    ) u_branch_lut (
        .i_idx   (bus.jumpIdx),
        .o_entry (w_entry)
    );

`ifdef RELATIVE_BRANCH_EN
    // Sign-extend the offset so negative entries wrap downward through zero
    assign w_target = r_pc + PC_W'(signed'(w_entry));
`else
    assign w_target = PC_W'(w_entry);
`endif

    assign w_pc_inc = r_pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pc      <= PC_START;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pc <= PC_START;
                    if (bus.start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                RUN: begin
                    // The halting cycle still counts as a run cycle
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (bus.haltReq) begin
                        r_state   <= HALTED;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (bus.jumpFlag) begin
                        r_pc <= w_target;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                HALTED: begin
                    if (bus.start) begin
                        r_state   <= RUN;
                        r_pc      <= PC_START;
                        r_cnt     <= '0;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pc      <= PC_START;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    assign bus.pc         = r_pc;
    assign bus.running    = r_running;
    assign bus.done       = r_done;
    assign bus.cycleCount = r_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; a second narrow-counter instance exercises saturation.
module tb_pc_fetch;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pc_fetch_if #(.PC_W(10), .LUT_IDX_W(4), .CNT_W(16)) bus ();
    pc_fetch_if #(.PC_W(10), .LUT_IDX_W(4), .CNT_W(8))  bus_s ();

    pc_fetch #(.PC_W(10), .LUT_IDX_W(4), .START_ADDR(0), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pc_fetch #(.PC_W(10), .LUT_IDX_W(4), .START_ADDR(0), .CNT_W(8)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.pc !== 10'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", bus.pc); end
        total++; if (bus.running !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL reset_flags got run=%b done=%b exp run=0 done=0", bus.running, bus.done); end
        total++; if (bus.cycleCount !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.cycleCount); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.pc !== 10'd0 || bus.running !== 1'b1) begin bad++; $display("FAIL start_first got pc=%0d run=%b exp pc=0 run=1", bus.pc, bus.running); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++; if (bus.pc !== 10'(k)) begin bad++; $display("FAIL seq_pc got=%0d exp=%0d", bus.pc, k); end
        end
        total++; if (bus.cycleCount !== 16'd5 || bus.running !== 1'b1) begin bad++; $display("FAIL seq_cnt got cnt=%0d run=%b exp cnt=5 run=1", bus.cycleCount, bus.running); end
    endtask

    task automatic test_jump();
        logic [9:0] exp_a;
        logic [9:0] exp_b;
        logic [9:0] exp_c;
        tick();
        tick();
        total++; if (bus.pc !== 10'd7) begin bad++; $display("FAIL jump_pre got=%0d exp=7", bus.pc); end
`ifdef RELATIVE_BRANCH_EN
        exp_a = 10'd47; exp_b = 10'd48; exp_c = 10'd48;
`else
        exp_a = 10'd40; exp_b = 10'd41; exp_c = 10'd0;
`endif
        bus.jumpFlag = 1'b1;
        bus.jumpIdx  = 4'd3;
        tick();
        total++; if (bus.pc !== exp_a) begin bad++; $display("FAIL jump_idx3 got=%0d exp=%0d", bus.pc, exp_a); end
        bus.jumpFlag = 1'b0;
        tick();
        total++; if (bus.pc !== exp_b) begin bad++; $display("FAIL jump_after got=%0d exp=%0d", bus.pc, exp_b); end
        bus.jumpFlag = 1'b1;
        bus.jumpIdx  = 4'd9;
        tick();
        total++; if (bus.pc !== exp_c) begin bad++; $display("FAIL jump_zero_entry got=%0d exp=%0d", bus.pc, exp_c); end
        bus.jumpFlag = 1'b0;
        tick();
        total++; if (bus.pc !== exp_c + 10'd1) begin bad++; $display("FAIL jump_zero_after got=%0d exp=%0d", bus.pc, exp_c + 10'd1); end
    endtask

    task automatic test_halt_priority();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (12) tick();
        total++; if (bus.pc !== 10'd12 || bus.cycleCount !== 16'd12) begin bad++; $display("FAIL halt_pre got pc=%0d cnt=%0d exp pc=12 cnt=12", bus.pc, bus.cycleCount); end
        bus.haltReq  = 1'b1;
        bus.jumpFlag = 1'b1;
        bus.jumpIdx  = 4'd3;
        tick();
        bus.haltReq = 1'b0;
        total++; if (bus.pc !== 10'd12) begin bad++; $display("FAIL halt_pc got=%0d exp=12", bus.pc); end
        total++; if (bus.done !== 1'b1 || bus.running !== 1'b0) begin bad++; $display("FAIL halt_flags got done=%b run=%b exp done=1 run=0", bus.done, bus.running); end
        total++; if (bus.cycleCount !== 16'd13) begin bad++; $display("FAIL halt_cnt got=%0d exp=13", bus.cycleCount); end
        repeat (3) tick();
        bus.jumpFlag = 1'b0;
        total++; if (bus.pc !== 10'd12 || bus.cycleCount !== 16'd13 || bus.done !== 1'b1) begin bad++; $display("FAIL halted_hold got pc=%0d cnt=%0d done=%b exp pc=12 cnt=13 done=1", bus.pc, bus.cycleCount, bus.done); end
    endtask

    task automatic test_restart();
        bus.start = 1'b1;
        tick();
        total++; if (bus.pc !== 10'd0 || bus.done !== 1'b0 || bus.cycleCount !== 16'd0 || bus.running !== 1'b1) begin bad++; $display("FAIL restart got pc=%0d done=%b cnt=%0d run=%b exp 0 0 0 1", bus.pc, bus.done, bus.cycleCount, bus.running); end
        tick();
        bus.start = 1'b0;
        total++; if (bus.pc !== 10'd1 || bus.cycleCount !== 16'd1) begin bad++; $display("FAIL start_in_run got pc=%0d cnt=%0d exp pc=1 cnt=1", bus.pc, bus.cycleCount); end
        repeat (8) tick();
        total++; if (bus.pc !== 10'd9) begin bad++; $display("FAIL pre_abort got=%0d exp=9", bus.pc); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.pc !== 10'd0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.cycleCount !== 16'd0) begin bad++; $display("FAIL abort got pc=%0d run=%b done=%b cnt=%0d exp 0 0 0 0", bus.pc, bus.running, bus.done, bus.cycleCount); end
        tick();
        tick();
        total++; if (bus.pc !== 10'd0 || bus.running !== 1'b0) begin bad++; $display("FAIL idle_hold got pc=%0d run=%b exp pc=0 run=0", bus.pc, bus.running); end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_w;
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.jumpFlag = 1'b1;
        bus.jumpIdx  = 4'd4;
        tick();
        bus.jumpFlag = 1'b0;
        total++; if (bus.pc !== 10'd1020) begin bad++; $display("FAIL jump_idx4 got=%0d exp=1020", bus.pc); end
        repeat (3) tick();
        total++; if (bus.pc !== 10'd1023) begin bad++; $display("FAIL pre_wrap got=%0d exp=1023", bus.pc); end
        tick();
        total++; if (bus.pc !== 10'd0 || bus.cycleCount !== 16'd5) begin bad++; $display("FAIL wrap got pc=%0d cnt=%0d exp pc=0 cnt=5", bus.pc, bus.cycleCount); end
        bus.jumpFlag = 1'b1;
        tick();
        bus.jumpFlag = 1'b0;
        tick();
        tick();
        total++; if (bus.pc !== 10'd1022) begin bad++; $display("FAIL pre_idx1 got=%0d exp=1022", bus.pc); end
`ifdef RELATIVE_BRANCH_EN
        exp_w = 10'd2;
`else
        exp_w = 10'd4;
`endif
        bus.jumpFlag = 1'b1;
        bus.jumpIdx  = 4'd1;
        tick();
        bus.jumpFlag = 1'b0;
        total++; if (bus.pc !== exp_w) begin bad++; $display("FAIL jump_idx1_high got=%0d exp=%0d", bus.pc, exp_w); end
    endtask

    task automatic test_offset();
        logic [9:0] exp_o;
        bus.haltReq = 1'b1;
        tick();
        bus.haltReq = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (20) tick();
        total++; if (bus.pc !== 10'd20) begin bad++; $display("FAIL pre_offset got=%0d exp=20", bus.pc); end
`ifdef RELATIVE_BRANCH_EN
        exp_o = 10'd16;
`else
        exp_o = 10'd1020;
`endif
        bus.jumpFlag = 1'b1;
        bus.jumpIdx  = 4'd4;
        tick();
        bus.jumpFlag = 1'b0;
        total++; if (bus.pc !== exp_o) begin bad++; $display("FAIL jump_idx4_at20 got=%0d exp=%0d", bus.pc, exp_o); end
    endtask

    task automatic test_saturation();
        bus_s.start = 1'b1;
        tick();
        bus_s.start = 1'b0;
        repeat (255) tick();
        total++; if (bus_s.cycleCount !== 8'd255 || bus_s.pc !== 10'd255) begin bad++; $display("FAIL sat_reach got cnt=%0d pc=%0d exp cnt=255 pc=255", bus_s.cycleCount, bus_s.pc); end
        repeat (10) tick();
        total++; if (bus_s.cycleCount !== 8'd255 || bus_s.pc !== 10'd265) begin bad++; $display("FAIL sat_hold got cnt=%0d pc=%0d exp cnt=255 pc=265", bus_s.cycleCount, bus_s.pc); end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.jumpFlag   = 1'b0;
        bus.jumpIdx    = 4'd0;
        bus.haltReq    = 1'b0;
        bus_s.start    = 1'b0;
        bus_s.jumpFlag = 1'b0;
        bus_s.jumpIdx  = 4'd0;
        bus_s.haltReq  = 1'b0;
        test_reset();
        test_sequential();
        test_jump();
        test_halt_priority();
        test_restart();
        test_wrap();
        test_offset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
